// File: rtl/batch_scheduler_pkg.sv
// Shared definitions for the batch scheduler.
//   slot_state_e    : per-core slot state encoding (IDLE/BUSY/DONE/DRAIN, 2 bits)
//   *_DEF           : default pixel geometry (NUM_PIXELS, PIXEL_WIDTH, batch width)
//   STALL_W         : width of the optional stall counter (BATCH_SCHED_STATS_EN)
//   ptr_width()     : width of a pointer that indexes n cores (at least 1 bit)
package batch_scheduler_pkg;

  typedef enum logic [1:0] {
    SLOT_IDLE  = 2'd0,
    SLOT_BUSY  = 2'd1,
    SLOT_DONE  = 2'd2,
    SLOT_DRAIN = 2'd3
  } slot_state_e;

  localparam int NUM_PIXELS_DEF  = 8;
  localparam int PIXEL_WIDTH_DEF = 12;
  localparam int BATCH_W_DEF     = NUM_PIXELS_DEF * PIXEL_WIDTH_DEF;
  localparam int STALL_W         = 16;

  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/batch_scheduler_core_slot.sv
// Tracks the life of one processor core's batch.
//   clk_i, reset_i : clock, synchronous active-high reset
//   start_i        : scheduler issued a batch to this core this cycle
//   done_i         : core finished (1-cycle pulse from the core)
//   retire_i       : scheduler moves this core's result into the fifo this cycle
//   flush_i        : new frame; abandon whatever this core holds
//   state_o        : current slot state (also serves as the debug view of the FSM)
module batch_scheduler_core_slot
  import batch_scheduler_pkg::*;
(
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic        done_i,
  input  logic        retire_i,
  input  logic        flush_i,
  output slot_state_e state_o
);

  slot_state_e state_q, state_d;

  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= SLOT_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      // The scheduler never issues in a flush cycle, so start needs no flush guard.
      SLOT_IDLE:  if (start_i) state_d = SLOT_BUSY;
      // A done landing in the flush cycle already satisfies the drain.
      SLOT_BUSY: begin
        if (flush_i)     state_d = done_i ? SLOT_IDLE : SLOT_DRAIN;
        else if (done_i) state_d = SLOT_DONE;
      end
      SLOT_DONE:  if (flush_i || retire_i) state_d = SLOT_IDLE;
      SLOT_DRAIN: if (done_i) state_d = SLOT_IDLE;
      default:    state_d = SLOT_IDLE;
    endcase
  end

  always_comb begin
    state_o = state_q;
  end

endmodule

// File: rtl/batch_scheduler.sv
// Spreads the pixel batches of one frame across NUM_CORES processors,
// issuing round-robin and retiring strictly in issue order into pixel_fifo.
//   clk, reset     : clock, synchronous active-high reset
//   new_frame      : pulse; abandon the current frame and restart at batch 0
//   fifo_room      : pixel_fifo can take one batch
//   core_start     : one-hot start pulse, batch_index valid alongside it
//   core_done      : per-core done pulse; core_result slice k held until next start
//   fifo_enqueue   : registered enqueue strobe, fifo_value registered data
//   frame_complete : level, every batch of the frame has been retired
//   stall_count    : only with BATCH_SCHED_STATS_EN; saturating count of cycles the
//                    fifo had room but the head slot had no result
// Core protocol: core_start[k] is a single-cycle command with no back-pressure;
// core k answers with exactly one core_done[k] pulse at least one cycle later and
// holds its result until its next start.
module batch_scheduler
  import batch_scheduler_pkg::*;
#(
  parameter int NUM_CORES         = 4,
  parameter int NUM_PIXELS        = NUM_PIXELS_DEF,
  parameter int PIXEL_WIDTH       = PIXEL_WIDTH_DEF,
  parameter int BATCHES_PER_FRAME = 9600,
  parameter int IDX_W             = 14
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      new_frame,
  input  logic                                      fifo_room,
  output logic [NUM_CORES-1:0]                      core_start,
  output logic [IDX_W-1:0]                          batch_index,
  input  logic [NUM_CORES-1:0]                      core_done,
  input  logic [NUM_CORES*NUM_PIXELS*PIXEL_WIDTH-1:0] core_result,
  output logic                                      fifo_enqueue,
  output logic [NUM_PIXELS*PIXEL_WIDTH-1:0]         fifo_value,
`ifdef BATCH_SCHED_STATS_EN
  output logic [STALL_W-1:0]                        stall_count,
`endif
  output logic                                      frame_complete
);

  localparam int BATCH_W = NUM_PIXELS * PIXEL_WIDTH;
  localparam int PTR_W   = ptr_width(NUM_CORES);
  localparam int CNT_W   = IDX_W + 1;  // must reach BATCHES_PER_FRAME itself
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_CORES - 1);
  localparam logic [CNT_W-1:0] CNT_END  = CNT_W'(BATCHES_PER_FRAME);

  slot_state_e          slot_state [NUM_CORES];
  logic [BATCH_W-1:0]   result_arr [NUM_CORES];
  logic [NUM_CORES-1:0] slot_start, slot_retire;
  logic                 issue_ok, retire_ok;

  logic [PTR_W-1:0]     issue_ptr_q, issue_ptr_d, retire_ptr_q, retire_ptr_d;
  logic [CNT_W-1:0]     issued_q, issued_d, retired_q, retired_d;
  logic [NUM_CORES-1:0] core_start_q, core_start_d;
  logic [IDX_W-1:0]     batch_index_q, batch_index_d;
  logic                 fifo_enqueue_q, fifo_enqueue_d;
  logic [BATCH_W-1:0]   fifo_value_q, fifo_value_d;
  logic                 frame_complete_q, frame_complete_d;

  for (genvar k = 0; k < NUM_CORES; k++) begin : g_slot
    assign result_arr[k] = core_result[k*BATCH_W +: BATCH_W];

    batch_scheduler_core_slot u_slot (
      .clk_i    (clk),
      .reset_i  (reset),
      .start_i  (slot_start[k]),
      .done_i   (core_done[k]),
      .retire_i (slot_retire[k]),
      .flush_i  (new_frame),
      .state_o  (slot_state[k])
    );
  end

  // A slot freed by retire only reads IDLE next cycle, so issue and retire can
  // never hit the same slot in one cycle.
  always_comb begin
    issue_ok    = (slot_state[issue_ptr_q] == SLOT_IDLE) && (issued_q < CNT_END) && !new_frame;
    retire_ok   = (slot_state[retire_ptr_q] == SLOT_DONE) && fifo_room && !new_frame;
    slot_start  = '0;
    slot_retire = '0;
    if (issue_ok)  slot_start[issue_ptr_q]   = 1'b1;
    if (retire_ok) slot_retire[retire_ptr_q] = 1'b1;
  end

  always_comb begin
    issue_ptr_d    = issue_ptr_q;
    retire_ptr_d   = retire_ptr_q;
    issued_d       = issued_q;
    retired_d      = retired_q;
    core_start_d   = slot_start;
    batch_index_d  = batch_index_q;
    fifo_enqueue_d = retire_ok;
    fifo_value_d   = fifo_value_q;
    if (new_frame) begin
      issue_ptr_d  = '0;
      retire_ptr_d = '0;
      issued_d     = '0;
      retired_d    = '0;
    end else begin
      if (issue_ok) begin
        batch_index_d = issued_q[IDX_W-1:0];
        issued_d      = issued_q + 1'b1;
        issue_ptr_d   = (issue_ptr_q == PTR_LAST) ? '0 : issue_ptr_q + 1'b1;
      end
      if (retire_ok) begin
        fifo_value_d = result_arr[retire_ptr_q];
        retired_d    = retired_q + 1'b1;
        retire_ptr_d = (retire_ptr_q == PTR_LAST) ? '0 : retire_ptr_q + 1'b1;
      end
    end
    // retired cannot pass the end, so this holds until the next restart.
    frame_complete_d = (retired_d == CNT_END);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      issue_ptr_q      <= '0;
      retire_ptr_q     <= '0;
      issued_q         <= '0;
      retired_q        <= '0;
      core_start_q     <= '0;
      batch_index_q    <= '0;
      fifo_enqueue_q   <= 1'b0;
      fifo_value_q     <= '0;
      frame_complete_q <= 1'b0;
    end else begin
      issue_ptr_q      <= issue_ptr_d;
      retire_ptr_q     <= retire_ptr_d;
      issued_q         <= issued_d;
      retired_q        <= retired_d;
      core_start_q     <= core_start_d;
      batch_index_q    <= batch_index_d;
      fifo_enqueue_q   <= fifo_enqueue_d;
      fifo_value_q     <= fifo_value_d;
      frame_complete_q <= frame_complete_d;
    end
  end

  assign core_start     = core_start_q;
  assign batch_index    = batch_index_q;
  assign fifo_enqueue   = fifo_enqueue_q;
  assign fifo_value     = fifo_value_q;
  assign frame_complete = frame_complete_q;

`ifdef BATCH_SCHED_STATS_EN
  logic [STALL_W-1:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (new_frame) begin
      stall_d = '0;
    end else if (fifo_room && (slot_state[retire_ptr_q] != SLOT_DONE) && (stall_q != '1)) begin
      stall_d = stall_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) stall_q <= '0;
    else       stall_q <= stall_d;
  end

  assign stall_count = stall_q;
`endif

endmodule

// File: tb/tb_batch_scheduler.sv
// Directed bench for batch_scheduler: 4 cores, 8 batches per frame.
module tb_batch_scheduler;

  localparam int NC   = 4;
  localparam int NPIX = 8;
  localparam int PW   = 12;
  localparam int BPF  = 8;
  localparam int IDXW = 14;
  localparam int BW   = NPIX * PW;

  // clock / reset block
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic               new_frame, fifo_room;
  logic [NC-1:0]      core_start, core_done;
  logic [IDXW-1:0]    batch_index;
  logic [NC*BW-1:0]   core_result;
  logic               fifo_enqueue, frame_complete;
  logic [BW-1:0]      fifo_value;
`ifdef BATCH_SCHED_STATS_EN
  logic [15:0]        stall_count;
`endif

  batch_scheduler #(
    .NUM_CORES(NC), .NUM_PIXELS(NPIX), .PIXEL_WIDTH(PW),
    .BATCHES_PER_FRAME(BPF), .IDX_W(IDXW)
  ) dut (
    .clk(clk), .reset(reset), .new_frame(new_frame), .fifo_room(fifo_room),
    .core_start(core_start), .batch_index(batch_index),
    .core_done(core_done), .core_result(core_result),
    .fifo_enqueue(fifo_enqueue), .fifo_value(fifo_value),
`ifdef BATCH_SCHED_STATS_EN
    .stall_count(stall_count),
`endif
    .frame_complete(frame_complete)
  );

  // scoreboard state
  int              errors = 0;
  int              checks = 0;
  logic [BW-1:0]   exp_q[$];
  int              enq_cnt = 0, start_cnt = 0;
  int              exp_idx = 0, exp_core = 0;
  bit              auto_en = 1'b0;
  int              ttl [NC] = '{default: 0};
  logic [IDXW-1:0] last_idx [NC] = '{default: '0};
  int              e0, s0;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [BW-1:0] pat(input int b);
    logic [BW-1:0] v;
    v = '0;
    for (int p = 0; p < NPIX; p++) v[p*PW +: PW] = PW'(b*256 + p*17 + 3);
    return v;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: observe outputs 2 time units after the edge, then drive.
  task automatic step();
    logic [NC-1:0] oh;
    @(posedge clk);
    #2;
    core_done = '0;
    for (int k = 0; k < NC; k++) begin
      if (ttl[k] > 0) begin
        ttl[k]--;
        if (ttl[k] == 0) begin
          core_done[k] = 1'b1;
          core_result[k*BW +: BW] = pat(int'(last_idx[k]));
        end
      end
    end
    if (core_start != '0) begin
      start_cnt++;
      oh = '0;
      oh[exp_core] = 1'b1;
      check("start_onehot", core_start, oh);
      check("start_index", batch_index, IDXW'(exp_idx));
      for (int k = 0; k < NC; k++) begin
        if (core_start[k]) begin
          last_idx[k] = batch_index;
          if (auto_en) ttl[k] = 3;
        end
      end
      exp_idx++;
      exp_core = (exp_core + 1) % NC;
    end
    if (fifo_enqueue) begin
      enq_cnt++;
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL enqueue_unexpected: observed value=%0h expected no enqueue", fifo_value);
      end
      if (exp_q.size() != 0) check("enqueue_value", fifo_value, exp_q.pop_front());
    end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic give_done(input int k, input int b);
    core_done[k] = 1'b1;
    core_result[k*BW +: BW] = pat(b);
  endtask

  task automatic pulse_new_frame();
    new_frame = 1'b1;
    exp_idx   = 0;
    exp_core  = 0;
    step();
    new_frame = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_core_start"}, core_start, '0);
    check({tag, "_fifo_enqueue"}, fifo_enqueue, 1'b0);
    check({tag, "_fifo_value"}, fifo_value, '0);
    check({tag, "_frame_complete"}, frame_complete, 1'b0);
    check({tag, "_batch_index"}, batch_index, '0);
  endtask

  initial begin
    reset       = 1'b1;
    new_frame   = 1'b0;
    fifo_room   = 1'b0;
    core_done   = '0;
    core_result = '0;
    steps(3);
    check_reset_outputs("reset");
`ifdef BATCH_SCHED_STATS_EN
    check("reset_stall_count", stall_count, 16'd0);
`endif

    // Full frame, done 3 cycles after each start, fifo always has room.
    for (int b = 0; b < BPF; b++) exp_q.push_back(pat(b));
    fifo_room = 1'b1;
    auto_en   = 1'b1;
    reset     = 1'b0;
    for (int i = 0; i < 60 && enq_cnt < BPF; i++) step();
    check("t1_enqueues", enq_cnt, BPF);
    check("t1_starts", start_cnt, BPF);
    check("t1_frame_complete", frame_complete, 1'b1);
    steps(3);
    check("t1_no_start_past_end", start_cnt, BPF);
    check("t1_complete_held", frame_complete, 1'b1);
    auto_en = 1'b0;

    // Core 1 finishes before core 0: results still leave in issue order.
    pulse_new_frame();
    check("t2_complete_cleared", frame_complete, 1'b0);
    s0 = start_cnt;
    steps(4);
    check("t2_four_starts", start_cnt - s0, 4);
    e0 = enq_cnt;
    give_done(1, 1);
    steps(3);
    check("t2_no_out_of_order", enq_cnt - e0, 0);
    exp_q.push_back(pat(0));
    exp_q.push_back(pat(1));
    give_done(0, 0);
    steps(4);
    check("t2_two_enqueues", enq_cnt - e0, 2);
    check("t2_refill_starts", start_cnt - s0, 6);

    // fifo full for 20 cycles with every core done.
    fifo_room = 1'b0;
    give_done(0, 4);
    give_done(1, 5);
    give_done(2, 2);
    give_done(3, 3);
    step();
    e0 = enq_cnt;
    s0 = start_cnt;
    steps(20);
    check("t3_stalled_enqueue", enq_cnt - e0, 0);
    check("t3_stalled_start", start_cnt - s0, 0);
    for (int b = 2; b <= 5; b++) exp_q.push_back(pat(b));
    fifo_room = 1'b1;
    steps(4);
    check("t3_back_to_back", enq_cnt - e0, 4);
    check("t3_restart_issue", start_cnt - s0, 2);

    // Finish the frame on the last two batches.
    exp_q.push_back(pat(6));
    exp_q.push_back(pat(7));
    give_done(2, 6);
    give_done(3, 7);
    steps(3);
    check("t3_tail_enqueues", enq_cnt - e0, 6);
    check("t3_frame_complete", frame_complete, 1'b1);

    // new_frame with cores 0,1 DONE and cores 2,3 BUSY.
    fifo_room = 1'b0;
    pulse_new_frame();
    check("t4_complete_cleared", frame_complete, 1'b0);
    s0 = start_cnt;
    steps(4);
    give_done(0, 0);
    give_done(1, 1);
    step();
    e0 = enq_cnt;
    fifo_room = 1'b1;
    pulse_new_frame();
    steps(4);
    check("t4_drain_blocks_issue", start_cnt - s0, 6);
    give_done(2, 99);
    give_done(3, 98);
    steps(4);
    check("t4_after_drain_starts", start_cnt - s0, 8);
    check("t4_nothing_enqueued", enq_cnt - e0, 0);

    // new_frame in the very cycle the head slot becomes retire-eligible.
    give_done(0, 0);
    step();
    e0 = enq_cnt;
    s0 = start_cnt;
    pulse_new_frame();
    steps(2);
    check("t5_no_enqueue", enq_cnt - e0, 0);
    give_done(1, 97);
    give_done(2, 96);
    give_done(3, 95);
    steps(4);
    check("t5_restart_starts", start_cnt - s0, 4);
    check("t5_still_no_enqueue", enq_cnt - e0, 0);

    // Reset mid-frame, then head BUSY with fifo room for 5 cycles.
    reset    = 1'b1;
    exp_idx  = 0;
    exp_core = 0;
    step();
    check_reset_outputs("midreset");
    reset     = 1'b0;
    fifo_room = 1'b0;
    step();
    fifo_room = 1'b1;
    steps(5);
    fifo_room = 1'b0;
`ifdef BATCH_SCHED_STATS_EN
    check("t6_stall_count", stall_count, 16'd5);
`endif
    step();
`ifdef BATCH_SCHED_STATS_EN
    check("t6_stall_hold", stall_count, 16'd5);
`endif
    pulse_new_frame();
`ifdef BATCH_SCHED_STATS_EN
    check("t6_stall_clear", stall_count, 16'd0);
`endif
    check("t6_no_enqueue", fifo_enqueue, 1'b0);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
